// File: rtl/teclado_pkg.sv
// rtl/teclado_pkg.sv - shared types, key map and helpers for the keypad scanner
package teclado_pkg;

    typedef enum logic [1:0] {
        ESCANEO,
        ANTIRREBOTE,
        PRESIONADA,
        LIBERACION
    } estado_teclado_t;

    // Row-major: MAPA_TECLAS[row][col]; '*' reports as E and '#' as F.
    localparam logic [3:0] MAPA_TECLAS [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic [3:0] codigo_tecla(input logic [1:0] row, input logic [1:0] col);
        return MAPA_TECLAS[row][col];
    endfunction

    // Lowest-index active (low) row wins when several rows are pulled down.
    function automatic logic [1:0] fila_activa(input logic [3:0] fs);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!fs[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sincronizador_filas.sv
// rtl/sincronizador_filas.sv - two-flop synchronizer for the asynchronous keypad rows
module sincronizador_filas #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;

    // Reset to all-ones so an idle (pulled-up) keypad is seen right after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '1;
            q_o    <= '1;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/lector_teclado.sv
// rtl/lector_teclado.sv - 4x4 keypad scanner with press/release debounce and one-shot key strobe
module lector_teclado
    import teclado_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] filas_i,
    output logic [3:0] columnas_o,
    output logic [3:0] teclado_o,
    output logic       key_detect_o,
    output logic       tecla_presionada_o
);

    localparam int SCAN_W = $clog2(SCAN_CYCLES) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_FULL  = DEB_W'(DEBOUNCE_CYCLES);

    logic [3:0] fs;

    sincronizador_filas #(
        .WIDTH (4)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (filas_i),
        .q_o     (fs)
    );

    estado_teclado_t   estado_q, estado_d;
    logic [1:0]        col_q, col_d;
    logic [1:0]        fila_q, fila_d;
    logic [SCAN_W-1:0] dwell_q, dwell_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    logic [3:0]        teclado_q, teclado_d;
    logic              detect_q, detect_d;
    logic              presionada_q, presionada_d;
    logic [3:0]        columnas_q, columnas_d;
    logic              fila_baja;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            estado_q     <= ESCANEO;
            col_q        <= 2'd0;
            fila_q       <= 2'd0;
            dwell_q      <= '0;
            deb_q        <= '0;
            teclado_q    <= 4'h0;
            detect_q     <= 1'b0;
            presionada_q <= 1'b0;
            columnas_q   <= 4'b1110;
        end else begin
            estado_q     <= estado_d;
            col_q        <= col_d;
            fila_q       <= fila_d;
            dwell_q      <= dwell_d;
            deb_q        <= deb_d;
            teclado_q    <= teclado_d;
            detect_q     <= detect_d;
            presionada_q <= presionada_d;
            columnas_q   <= columnas_d;
        end
    end

    assign fila_baja = ~fs[fila_q];

    always_comb begin
        estado_d  = estado_q;
        col_d     = col_q;
        fila_d    = fila_q;
        dwell_d   = dwell_q;
        deb_d     = deb_q;
        teclado_d = teclado_q;
        detect_d  = 1'b0;

        unique case (estado_q)
            ESCANEO: begin
                // Rows are only trusted on the last dwell cycle, after the sync latency.
                if (dwell_q >= SCAN_LAST) begin
                    dwell_d = '0;
                    if (fs != 4'hF) begin
                        fila_d   = fila_activa(fs);
                        deb_d    = '0;
                        estado_d = ANTIRREBOTE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + SCAN_W'(1);
                end
            end
            ANTIRREBOTE: begin
                if (!fila_baja) begin
                    estado_d = ESCANEO;
                    col_d    = col_q + 2'd1;
                    dwell_d  = '0;
                    deb_d    = '0;
                end else if (deb_q >= DEB_LAST) begin
                    deb_d     = DEB_FULL;
                    teclado_d = codigo_tecla(fila_q, col_q);
                    detect_d  = 1'b1;
                    estado_d  = PRESIONADA;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            PRESIONADA: begin
                if (!fila_baja) begin
                    estado_d = LIBERACION;
                    deb_d    = '0;
                end
            end
            LIBERACION: begin
                // A bounce during release returns to the held state without a new strobe.
                if (fila_baja) begin
                    estado_d = PRESIONADA;
                end else if (deb_q >= DEB_LAST) begin
                    deb_d    = DEB_FULL;
                    estado_d = ESCANEO;
                    col_d    = col_q + 2'd1;
                    dwell_d  = '0;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: begin
                estado_d = ESCANEO;
            end
        endcase

        presionada_d = (estado_d == PRESIONADA) || (estado_d == LIBERACION);
        columnas_d   = ~(4'b0001 << col_d);
    end

    assign columnas_o         = columnas_q;
    assign teclado_o          = teclado_q;
    assign key_detect_o       = detect_q;
    assign tecla_presionada_o = presionada_q;

endmodule

// File: tb/tb_lector_teclado.sv
// tb/tb_lector_teclado.sv - self-checking bench for lector_teclado with a keypad model
module tb_lector_teclado;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  teclado;
    logic        det;
    logic        pres;
    logic [15:0] pressed = '0;

    always #5 clk = ~clk;

    // A pressed key shorts its row to its column; rows idle high.
    always_comb begin
        filas = 4'hF;
        for (int r = 0; r < 4; r++) begin
            filas[r] = ~|(pressed[r*4 +: 4] & ~columnas);
        end
    end

    lector_teclado #(
        .SCAN_CYCLES     (SCAN),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .filas_i            (filas),
        .columnas_o         (columnas),
        .teclado_o          (teclado),
        .key_detect_o       (det),
        .tecla_presionada_o (pres)
    );

    typedef struct {
        int         r;
        int         c;
        int         hold;
        int         npulse;
        logic [3:0] code;
    } vec_t;

    vec_t       tbl [10];
    logic [3:0] ref_map [16];

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pulse = -1;
    int         viol = 0;
    logic       prev_det = 1'b0;
    logic [3:0] col_now = 4'hF;
    logic [3:0] col_prev = 4'hF;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (det) begin
            pulses++;
            last_pulse = cyc;
            if (prev_det) viol++;
        end
        prev_det = det;
        if (!(columnas inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})) viol++;
        col_prev = col_now;
        col_now  = columnas;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Align to the first cycle of column 0 so press timing is known exactly.
    task automatic sync_col0();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(col_now == 4'b1110 && col_prev == 4'b0111) && n < 64);
        check("sync_col0_found", int'(n < 64), 1);
    endtask

    task automatic press_key(input int r, input int c);
        pressed[r*4 + c] = 1'b1;
    endtask

    initial begin
        int c0, p0, r, c, k, R;
        logic [3:0] e;

        ref_map = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                    4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        tbl[0] = '{0, 1, 40, 1, 4'h2};
        tbl[1] = '{1, 0, 40, 1, 4'h4};
        tbl[2] = '{2, 2, 40, 1, 4'h9};
        tbl[3] = '{0, 3,  3, 0, 4'h9};
        tbl[4] = '{3, 1, 40, 1, 4'h0};
        tbl[5] = '{2, 3, 40, 1, 4'hC};
        tbl[6] = '{3, 0, 40, 1, 4'hE};
        tbl[7] = '{1, 3,  2, 0, 4'hE};
        tbl[8] = '{2, 0, 40, 1, 4'h7};
        tbl[9] = '{1, 1, 40, 1, 4'h5};

        // 1. reset values and column scan order
        reset_i = 1'b1;
        run(3);
        check("rst_columnas", int'(columnas), 'hE);
        check("rst_teclado", int'(teclado), 0);
        check("rst_detect", int'(det), 0);
        check("rst_presionada", int'(pres), 0);
        reset_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = ~(4'b0001 << (i / SCAN));
            check("scan_columnas", int'(columnas), int'(e));
            if (i < 15) step();
        end

        // 2. single clean press r1/c2
        sync_col0();
        c0 = cyc; p0 = pulses;
        press_key(1, 2);
        run(60);
        check("p2_pulses", pulses - p0, 1);
        check("p2_latency", last_pulse - c0, 2*SCAN + SCAN - 1 + DEB + 1);
        check("p2_teclado", int'(teclado), 'h6);
        check("p2_presionada", int'(pres), 1);
        pressed = '0;
        run(30);

        // 3. three-cycle bounce on r0/c0
        sync_col0();
        c0 = cyc; p0 = pulses;
        press_key(0, 0);
        run(3);
        pressed = '0;
        run(1);
        check("p3_frozen", int'(columnas), 'hE);
        run(2);
        check("p3_resume_col1", int'(columnas), 'hD);
        run(30);
        check("p3_pulses", pulses - p0, 0);
        check("p3_teclado", int'(teclado), 'h6);

        // 4. long hold of r3/c3 with short release glitches
        sync_col0();
        c0 = cyc; p0 = pulses;
        press_key(3, 3);
        run(40);
        pressed = '0; run(5); press_key(3, 3);
        run(25);
        pressed = '0; run(5); press_key(3, 3);
        run(25);
        check("p4_pulses", pulses - p0, 1);
        check("p4_latency", last_pulse - c0, 4*SCAN - 1 + DEB + 1);
        check("p4_teclado", int'(teclado), 'hD);
        check("p4_presionada", int'(pres), 1);
        R = cyc;
        pressed = '0;
        run(12);
        check("p4_released", int'(pres), 0);
        check("p4_col_after_rel", int'(columnas), 'hE);
        run(4);
        check("p4_scan_resumed", int'(columnas), 'hD);
        check("p4_no_extra_pulse", pulses - p0, 1);

        // 5. two keys together, then '#'
        sync_col0();
        c0 = cyc; p0 = pulses;
        press_key(0, 0);
        press_key(3, 3);
        run(60);
        check("p5_pulses", pulses - p0, 1);
        check("p5_latency", last_pulse - c0, SCAN - 1 + DEB + 1);
        check("p5_teclado", int'(teclado), 'h1);
        pressed = '0;
        run(30);
        sync_col0();
        c0 = cyc; p0 = pulses;
        press_key(3, 2);
        run(60);
        check("p5_hash_pulses", pulses - p0, 1);
        check("p5_hash_latency", last_pulse - c0, 3*SCAN - 1 + DEB + 1);
        check("p5_hash_teclado", int'(teclado), 'hF);
        pressed = '0;
        run(30);

        // 6. reset on the fourth debounce cycle
        sync_col0();
        p0 = pulses;
        press_key(0, 0);
        run(7);
        reset_i = 1'b1;
        pressed = '0;
        step();
        check("p6_columnas", int'(columnas), 'hE);
        check("p6_teclado", int'(teclado), 0);
        check("p6_detect", int'(det), 0);
        check("p6_presionada", int'(pres), 0);
        reset_i = 1'b0;
        run(30);
        check("p6_no_pulse", pulses - p0, 0);

        // table-driven key map vectors
        for (int i = 0; i < 10; i++) begin
            p0 = pulses;
            press_key(tbl[i].r, tbl[i].c);
            run(tbl[i].hold);
            pressed = '0;
            run(20);
            check("tbl_pulses", pulses - p0, tbl[i].npulse);
            check("tbl_teclado", int'(teclado), int'(tbl[i].code));
        end

        // randomized presses with optional bounce against the key-map model
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            k = r*4 + c;
            p0 = pulses;
            if ($urandom_range(0, 1) == 1) begin
                press_key(r, c);
                run($urandom_range(1, 5));
                pressed = '0;
                run($urandom_range(4, 8));
            end
            press_key(r, c);
            run($urandom_range(40, 60));
            pressed = '0;
            run($urandom_range(20, 40));
            check("rnd_pulses", pulses - p0, 1);
            check("rnd_teclado", int'(teclado), int'(ref_map[k]));
        end

        check("strobe_and_column_invariants", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
